// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the sequential divider.
package alu_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Quotient reported when the divisor is zero (all ones).
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           take;

  // Shift {rem, quo} left by one; the quotient MSB feeds the remainder.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  // A set rem MSB means the shifted value exceeds any WIDTH-bit divisor,
  // so the subtraction cannot go negative even though trial[WIDTH] is set.
  assign take = rem[WIDTH-1] | ~trial[WIDTH];

  // Restore on a negative trial, otherwise keep the difference.
  assign rem_next = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], take};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, signed/unsigned, WIDTH steps per result.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ZERO_QUO = {WIDTH{DIV_ZERO_QUO[0]}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_orig_q;
  logic             signed_q, dvd_neg_q, dvs_neg_q, dvz_q;
  logic             accept, last_step;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fix, r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Operand magnitudes and sign correction of the final step result.
  assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign q_fix   = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? -step_quo : step_quo;
  assign r_fix   = (signed_q && dvd_neg_q) ? -step_rem : step_rem;

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered busy/done derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Operand latches and iteration datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_orig_q <= '0;
      signed_q   <= 1'b0;
      dvd_neg_q  <= 1'b0;
      dvs_neg_q  <= 1'b0;
      dvz_q      <= 1'b0;
    end else if (accept) begin
      cnt_q      <= CNT_W'(WIDTH - 1);
      rem_q      <= '0;
      quo_q      <= dvd_mag;
      dvs_q      <= dvs_mag;
      dvd_orig_q <= dividend;
      signed_q   <= is_signed;
      dvd_neg_q  <= dividend[WIDTH-1];
      dvs_neg_q  <= divisor[WIDTH-1];
      dvz_q      <= (divisor == '0);
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - CNT_W'(1);
      rem_q <= step_rem;
      quo_q <= step_quo;
    end
  end

  // Result registers, written only on the final iteration edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (last_step) begin
      if (dvz_q) begin
        quotient  <= ZERO_QUO;
        remainder <= dvd_orig_q;
      end else begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
      div_by_zero <= dvz_q;
    end
  end

endmodule
